// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Pipeline memory-access stage. Takes the EX result (address or
//             ALU value) and store operand, issues at most one load/store on
//             an SRAM-like request/response bus, aligns and extends load data,
//             flags misaligned accesses, and presents a registered result to
//             write-back under a valid/ready handshake.
//  Ports    : clk/resetn          - clock, async active-low reset
//             in_*                - instruction from EX (valid/ready)
//             data_*              - data bus request / response channel
//             out_*               - result, write enable and exceptions to WB
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int          REG_AW   = 5,
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic              clk,
    input  logic              resetn,
    // EX -> MEM
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_result,
    input  logic [31:0]       in_store,
    input  logic [3:0]        in_mem_op,
    input  logic              in_wen,
    input  logic [REG_AW-1:0] in_dest,
    // data bus
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    // MEM -> WB
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_result,
    output logic              out_wen,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_adel,
    output logic              out_ades,
    output logic [31:0]       out_badvaddr
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [3:0] c_OP_NONE = 4'd0;
    localparam logic [3:0] c_OP_LB   = 4'd1;
    localparam logic [3:0] c_OP_LBU  = 4'd2;
    localparam logic [3:0] c_OP_LH   = 4'd3;
    localparam logic [3:0] c_OP_LHU  = 4'd4;
    localparam logic [3:0] c_OP_LW   = 4'd5;
    localparam logic [3:0] c_OP_SB   = 4'd6;
    localparam logic [3:0] c_OP_SH   = 4'd7;
    localparam logic [3:0] c_OP_SW   = 4'd8;

    logic [1:0]  r_state;
    logic [1:0]  w_next;

    // latched instruction fields that drive the bus
    logic [3:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_store;

    logic [31:0]       r_out_pc;
    logic [31:0]       r_out_result;
    logic [31:0]       r_out_badvaddr;
    logic              r_out_wen;
    logic              r_out_adel;
    logic              r_out_ades;
    logic [REG_AW-1:0] r_out_dest;

    logic        w_accept;
    logic [3:0]  w_in_op;
    logic        w_in_mem;
    logic        w_in_store;
    logic        w_in_fault;
    logic        w_ld_r;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    // ------------------------------------------------------------------
    // Incoming op decode. Codes 9..15 fold to "none" here so that the
    // latched op never holds an undefined encoding.
    // ------------------------------------------------------------------
    always_comb begin
        w_in_op    = (in_mem_op > c_OP_SW) ? c_OP_NONE : in_mem_op;
        w_in_mem   = (w_in_op != c_OP_NONE);
        w_in_store = (w_in_op >= c_OP_SB);
        w_in_fault = 1'b0;
        case (w_in_op)
            c_OP_LH, c_OP_LHU, c_OP_SH: w_in_fault = in_result[0];
            c_OP_LW, c_OP_SW:           w_in_fault = |in_result[1:0];
            default:                    w_in_fault = 1'b0;
        endcase
    end

    assign w_accept = in_valid & in_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. DONE may accept a new instruction on the same edge
    // that WB takes the current one, so IDLE and DONE share the accept path.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (w_accept) begin
                    // misaligned accesses retire immediately without a bus cycle
                    w_next = (w_in_mem && !w_in_fault) ? c_REQ : c_DONE;
                end else if (r_state == c_DONE && out_ready) begin
                    w_next = c_IDLE;
                end
            end
            c_REQ:   if (data_addr_ok) w_next = c_WAIT;
            c_WAIT:  if (data_data_ok) w_next = c_DONE;
            default: w_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (r_state == c_IDLE) || ((r_state == c_DONE) && out_ready);
        data_req  = (r_state == c_REQ);
        out_valid = (r_state == c_DONE);
    end

    // ------------------------------------------------------------------
    // Bus fields come only from latched registers, so they are stable for
    // the whole time data_req is high.
    // ------------------------------------------------------------------
    always_comb begin
        data_addr  = r_addr;
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_wstrb = 4'b0000;
        data_wdata = r_store;
        case (r_op)
            c_OP_LB, c_OP_LBU: data_size = 2'd0;
            c_OP_LH, c_OP_LHU: data_size = 2'd1;
            c_OP_LW:           data_size = 2'd2;
            c_OP_SB: begin
                data_wr    = 1'b1;
                data_size  = 2'd0;
                data_wstrb = 4'b0001 << r_addr[1:0];
                data_wdata = {4{r_store[7:0]}};
            end
            c_OP_SH: begin
                data_wr    = 1'b1;
                data_size  = 2'd1;
                data_wstrb = 4'b0011 << r_addr[1:0];
                data_wdata = {2{r_store[15:0]}};
            end
            c_OP_SW: begin
                data_wr    = 1'b1;
                data_size  = 2'd2;
                data_wstrb = 4'b1111;
                data_wdata = r_store;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane selection and extension
    // ------------------------------------------------------------------
    always_comb begin
        w_ld_r = (r_op != c_OP_NONE) && (r_op < c_OP_SB);
        case (r_addr[1:0])
            2'd0:    w_byte = data_rdata[7:0];
            2'd1:    w_byte = data_rdata[15:8];
            2'd2:    w_byte = data_rdata[23:16];
            default: w_byte = data_rdata[31:24];
        endcase
        w_half = r_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (r_op)
            c_OP_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: w_load_data = {24'd0, w_byte};
            c_OP_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            c_OP_LHU: w_load_data = {16'd0, w_half};
            default:  w_load_data = data_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op           <= c_OP_NONE;
            r_addr         <= 32'd0;
            r_store        <= 32'd0;
            r_out_pc       <= RESET_PC;
            r_out_result   <= 32'd0;
            r_out_badvaddr <= 32'd0;
            r_out_wen      <= 1'b0;
            r_out_adel     <= 1'b0;
            r_out_ades     <= 1'b0;
            r_out_dest     <= '0;
        end else if (w_accept) begin
            // a faulting op never reaches the bus, so it is latched as "none"
            r_op           <= w_in_fault ? c_OP_NONE : w_in_op;
            r_addr         <= in_result;
            r_store        <= in_store;
            r_out_pc       <= in_pc;
            r_out_result   <= in_result;
            r_out_badvaddr <= w_in_fault ? in_result : 32'd0;
            r_out_wen      <= in_wen & ~w_in_fault;
            r_out_adel     <= w_in_fault & ~w_in_store;
            r_out_ades     <= w_in_fault &  w_in_store;
            r_out_dest     <= in_dest;
        end else if (r_state == c_WAIT && data_data_ok) begin
            r_out_result   <= w_ld_r ? w_load_data : r_addr;
        end
    end

    assign out_pc       = r_out_pc;
    assign out_result   = r_out_result;
    assign out_wen      = r_out_wen;
    assign out_dest     = r_out_dest;
    assign out_adel     = r_out_adel;
    assign out_ades     = r_out_ades;
    assign out_badvaddr = r_out_badvaddr;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage. A table of hand-computed
//             vectors, directed reset/bubble sequences, then randomized ops
//             with random bus latencies and WB stalls checked against a
//             behavioural byte-lane model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int          REG_AW   = 5;
    localparam logic [31:0] RESET_PC = 32'hBFC00000;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_pc = '0;
    logic [31:0]       in_result = '0;
    logic [31:0]       in_store = '0;
    logic [3:0]        in_mem_op = '0;
    logic              in_wen = 1'b0;
    logic [REG_AW-1:0] in_dest = '0;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [31:0]       data_addr;
    logic [3:0]        data_wstrb;
    logic [31:0]       data_wdata;
    logic              data_addr_ok = 1'b0;
    logic              data_data_ok = 1'b0;
    logic [31:0]       data_rdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_pc;
    logic [31:0]       out_result;
    logic              out_wen;
    logic [REG_AW-1:0] out_dest;
    logic              out_adel;
    logic              out_ades;
    logic [31:0]       out_badvaddr;

    always #5 clk = ~clk;

    mem_stage #(.REG_AW(REG_AW), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_result(in_result), .in_store(in_store), .in_mem_op(in_mem_op),
        .in_wen(in_wen), .in_dest(in_dest),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_result(out_result), .out_wen(out_wen), .out_dest(out_dest),
        .out_adel(out_adel), .out_ades(out_ades), .out_badvaddr(out_badvaddr)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] rdata;
        logic        wen;
        int          ad;      // cycles data_addr_ok is withheld
        int          dd;      // extra cycles before data_data_ok
        int          stall;   // cycles out_ready is held low in DONE
        logic [31:0] e_result;
        logic        e_wen;
        logic        e_adel;
        logic        e_ades;
        logic        e_req;
        logic [1:0]  e_size;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte counts, lane offsets and plain arithmetic.
    function automatic vec_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] st, input logic [31:0] rd,
                                   input logic w);
        vec_t        e;
        int          off;
        int          nb;
        bit          ld;
        bit          sto;
        bit          flt;
        logic [31:0] mask;
        logic [31:0] v;
        e       = '{default: 0};
        e.op    = op;
        e.addr  = a;
        e.store = st;
        e.rdata = rd;
        e.wen   = w;
        off     = int'(a % 32'd4);
        case (op)
            4'd1, 4'd2, 4'd6: nb = 1;
            4'd3, 4'd4, 4'd7: nb = 2;
            4'd5, 4'd8:       nb = 4;
            default:          nb = 0;
        endcase
        ld        = (op >= 4'd1) && (op <= 4'd5);
        sto       = (op >= 4'd6) && (op <= 4'd8);
        flt       = (nb > 1) && ((off % nb) != 0);
        e.e_adel  = ld && flt;
        e.e_ades  = sto && flt;
        e.e_req   = (nb > 0) && !flt;
        e.e_wen   = flt ? 1'b0 : w;
        e.e_size  = (nb == 4) ? 2'd2 : (nb == 2) ? 2'd1 : 2'd0;
        e.e_wstrb = sto ? 4'(((1 << nb) - 1) << off) : 4'd0;
        if (nb == 1)      e.e_wdata = {24'd0, st[7:0]} * 32'h01010101;
        else if (nb == 2) e.e_wdata = {16'd0, st[15:0]} * 32'h00010001;
        else              e.e_wdata = st;
        if (ld) begin
            if (nb == 4) begin
                v = rd;
            end else begin
                mask = (32'd1 << (8 * nb)) - 32'd1;
                v    = (rd >> (8 * off)) & mask;
                if ((op == 4'd1 || op == 4'd3) && v[8*nb-1]) v = v | ~mask;
            end
            e.e_result = v;
        end else begin
            e.e_result = a;
        end
        return e;
    endfunction

    // Present one instruction (accepting on the same edge WB takes the
    // previous one), act as the bus slave, and check everything it produces.
    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0]       pc;
        logic [REG_AW-1:0] dest;
        int                phase;
        int                acnt;
        int                dcnt;
        int                stall;
        int                lat;
        int                exp_lat;
        bit                saw_req;
        bit                done;
        bit                is_st;
        bit                fault;
        pc      = 32'h00400000 + 32'(idx * 4);
        dest    = REG_AW'(idx);
        is_st   = (v.op >= 4'd6) && (v.op <= 4'd8);
        fault   = v.e_adel | v.e_ades;
        exp_lat = v.e_req ? (3 + v.ad + v.dd) : 1;
        @(negedge clk);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_result    = v.addr;
        in_store     = v.store;
        in_mem_op    = v.op;
        in_wen       = v.wen;
        in_dest      = dest;
        out_ready    = 1'b1;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        #1;
        chk1("in_ready_at_accept", in_ready, 1'b1);
        phase = 0; acnt = v.ad; dcnt = v.dd; stall = v.stall;
        saw_req = 1'b0; done = 1'b0; lat = 0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            in_valid     = 1'b0;
            out_ready    = 1'b0;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = $urandom;
            if (phase != 0) begin
                chk1("req_low_after_addr_ok", data_req, 1'b0);
            end
            if (phase == 1) begin
                if (dcnt == 0) begin
                    data_data_ok = 1'b1;
                    data_rdata   = v.rdata;
                    phase        = 2;
                end else begin
                    dcnt--;
                end
            end else if (phase == 0 && data_req) begin
                saw_req = 1'b1;
                chk("data_addr", data_addr, v.addr);
                chk("data_size", 32'(data_size), 32'(v.e_size));
                chk1("data_wr", data_wr, is_st);
                chk("data_wstrb", 32'(data_wstrb), 32'(v.e_wstrb));
                if (is_st) chk("data_wdata", data_wdata, v.e_wdata);
                if (acnt == 0) begin
                    data_addr_ok = 1'b1;
                    phase        = 1;
                end else begin
                    acnt--;
                end
            end
            #1;
            if (out_valid) begin
                if (lat == 0) begin
                    lat = c;
                    chk("latency", 32'(lat), 32'(exp_lat));
                    chk1("req_issued", saw_req, v.e_req);
                end
                chk("out_pc", out_pc, pc);
                chk("out_dest", 32'(out_dest), 32'(dest));
                chk1("out_wen", out_wen, v.e_wen);
                chk1("out_adel", out_adel, v.e_adel);
                chk1("out_ades", out_ades, v.e_ades);
                if (fault) chk("out_badvaddr", out_badvaddr, v.addr);
                else       chk("out_result", out_result, v.e_result);
                chk1("in_ready_stalled", in_ready, 1'b0);
                if (stall == 0) done = 1'b1;
                else            stall--;
            end else begin
                chk1("in_ready_busy", in_ready, 1'b0);
            end
        end
        if (!done) chk1("timeout_out_valid", 1'b0, 1'b1);
    endtask

    initial begin
        vec_t v;
        //            op     addr          store         rdata         wen ad dd st  e_result      wen adl ads req sz    wstrb    wdata
        tbl[0]  = '{4'd0,  32'h00000007, 32'h0,        32'h0,        1'b1, 0, 0, 0, 32'h00000007, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0};
        tbl[1]  = '{4'd1,  32'h80000003, 32'h0,        32'h80FF1234, 1'b1, 0, 1, 0, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 32'h0};
        tbl[2]  = '{4'd2,  32'h80000001, 32'h0,        32'h80FF1234, 1'b1, 1, 0, 0, 32'h00000012, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 32'h0};
        tbl[3]  = '{4'd3,  32'h80000002, 32'h0,        32'h80FF1234, 1'b1, 0, 0, 0, 32'hFFFF80FF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 32'h0};
        tbl[4]  = '{4'd4,  32'h80000000, 32'h0,        32'h80FF9234, 1'b1, 0, 0, 3, 32'h00009234, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 32'h0};
        tbl[5]  = '{4'd5,  32'h80000004, 32'h0,        32'hDEADBEEF, 1'b1, 2, 2, 0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 32'h0};
        tbl[6]  = '{4'd6,  32'h80000001, 32'h123456AB, 32'h0,        1'b0, 0, 0, 0, 32'h80000001, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0010, 32'hABABABAB};
        tbl[7]  = '{4'd7,  32'h80000002, 32'h0000BEEF, 32'h0,        1'b0, 0, 0, 0, 32'h80000002, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1100, 32'hBEEFBEEF};
        tbl[8]  = '{4'd8,  32'h80000008, 32'hCAFEF00D, 32'h0,        1'b0, 1, 1, 1, 32'h80000008, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b1111, 32'hCAFEF00D};
        tbl[9]  = '{4'd5,  32'h80000006, 32'h0,        32'h0,        1'b1, 0, 0, 0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 32'h0};
        tbl[10] = '{4'd3,  32'h80000001, 32'h0,        32'h0,        1'b1, 0, 0, 0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 32'h0};
        tbl[11] = '{4'd8,  32'h80000002, 32'h11111111, 32'h0,        1'b0, 0, 0, 0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000, 32'h0};
        tbl[12] = '{4'd7,  32'h80000003, 32'h22222222, 32'h0,        1'b0, 0, 0, 0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 32'h0};
        tbl[13] = '{4'd12, 32'h000055AA, 32'h0,        32'h0,        1'b1, 0, 0, 0, 32'h000055AA, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0};
        tbl[14] = '{4'd6,  32'h80000003, 32'hFFFFFF7E, 32'h0,        1'b0, 0, 0, 0, 32'h80000003, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1000, 32'h7E7E7E7E};
        tbl[15] = '{4'd1,  32'h80000000, 32'h0,        32'h0000007F, 1'b1, 0, 0, 0, 32'h0000007F, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 32'h0};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_data_req", data_req, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_pc", out_pc, RESET_PC);
        chk("rst_out_result", out_result, 32'h0);
        chk1("rst_out_wen", out_wen, 1'b0);
        chk1("rst_out_adel", out_adel, 1'b0);
        chk1("rst_out_ades", out_ades, 1'b0);
        chk("rst_out_badvaddr", out_badvaddr, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(tbl[i], i);

        // bubble: WB takes the result with nothing behind it -> IDLE
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk1("bubble_in_ready", in_ready, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk1("bubble_out_valid", out_valid, 1'b0);
        chk1("bubble_idle_ready", in_ready, 1'b1);

        // reset while a load waits for its data
        @(negedge clk);
        in_valid  = 1'b1;
        in_mem_op = 4'd5;
        in_result = 32'h80000010;
        in_pc     = 32'h00401000;
        in_wen    = 1'b1;
        in_dest   = 5'd9;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk1("mid_req", data_req, 1'b1);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        #1;
        chk1("mid_wait_req", data_req, 1'b0);
        #1;
        resetn = 1'b0;
        #1;
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_out_pc", out_pc, RESET_PC);
        chk("mid_rst_out_result", out_result, 32'h0);
        chk1("mid_rst_out_wen", out_wen, 1'b0);
        chk("mid_rst_out_dest", 32'(out_dest), 32'h0);
        chk1("mid_rst_data_req", data_req, 1'b0);
        @(negedge clk);
        resetn       = 1'b1;
        data_data_ok = 1'b1;   // stray completion in IDLE must be ignored
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            data_data_ok = 1'b0;
            #1;
            chk1("post_rst_req", data_req, 1'b0);
            chk1("post_rst_valid", out_valid, 1'b0);
        end

        // randomized ops against the model
        for (int i = 0; i < 150; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            op       = 4'($urandom_range(0, 15));
            a        = $urandom;
            v        = model(op, a, $urandom, $urandom,
                             (op >= 4'd6 && op <= 4'd8) ? 1'b0 : 1'($urandom_range(0, 1)));
            v.ad     = $urandom_range(0, 3);
            v.dd     = $urandom_range(0, 3);
            v.stall  = $urandom_range(0, 2);
            run_vec(v, 32 + i);
        end

        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, miscompares so far %0d", n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage, directly downstream of the execute stage.
- Consumes the execute result (address or ALU value) and the store operand from the EX/MEM boundary.
- Performs loads and stores over an SRAM-like request/response data bus: byte enables, load alignment and extension, address-error detection.
- Hands a registered result to write-back under a valid/ready handshake and back-pressures execute while a memory access is outstanding.

Parameters:
- REG_AW, 5, destination register address width.
- RESET_PC, 32'hBFC00000, value that out_pc resets to.

Ports:
- clk  in  1  single system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX presents an instruction.
- in_ready  out  1  stage can accept the instruction this cycle.
- in_pc  in  32  instruction PC.
- in_result  in  32  EX result; this is the effective address for memory ops.
- in_store  in  32  store data (rt value).
- in_mem_op  in  4  operation: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 are treated as none.
- in_wen  in  1  register write enable.
- in_dest  in  REG_AW  destination register.
- data_req  out  1  bus request.
- data_wr  out  1  1 = store.
- data_size  out  2  0 byte, 1 half, 2 word.
- data_addr  out  32  bus address.
- data_wstrb  out  4  byte strobes.
- data_wdata  out  32  lane-aligned store data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response or write completion.
- data_rdata  in  32  read data.
- out_valid  out  1  result valid to WB.
- out_ready  in  1  WB accepts.
- out_pc  out  32  PC passed to WB.
- out_result  out  32  WB value.
- out_wen  out  1  register write enable to WB.
- out_dest  out  REG_AW  destination register to WB.
- out_adel  out  1  load address error.
- out_ades  out  1  store address error.
- out_badvaddr  out  32  faulting address.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - out_valid, out_wen, out_adel, out_ades, data_req = 0.
  - out_pc = RESET_PC.
  - out_result, out_dest, out_badvaddr = 0.
- States: IDLE, REQ, WAIT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). An instruction is accepted when in_valid & in_ready.
- On accept, all inputs are latched into stage registers. Next state:
  - mem_op none → DONE.
  - mem_op is a memory op and misaligned → DONE, with out_adel (load) or out_ades (store) = 1, out_badvaddr = in_result, out_wen = 0. No bus request is issued.
  - otherwise → REQ.
- Misalignment:
  - Half ops fault when addr[0] ≠ 0.
  - Word ops fault when addr[1:0] ≠ 0.
- Accept with no instruction: DONE & out_ready & !in_valid → IDLE.
- REQ:
  - data_req = 1; data_addr, data_size, data_wr, data_wstrb, data_wdata are driven from the latched registers.
  - All bus fields stay stable until data_addr_ok.
  - On data_addr_ok → WAIT. data_req drops the same edge.
- WAIT:
  - On data_data_ok → DONE.
  - Loads latch out_result = extracted data.
  - Stores latch out_result = latched in_result.
  - At most one bus transaction is outstanding at any time.
- DONE: out_valid = 1, and outputs are held until out_ready.
- Latency:
  - Non-memory op: accepted at cycle N → out_valid at N+1.
  - Load with addr_ok at N+1 and data_ok at N+2 → out_valid at N+3.
- Store strobes and data, by address byte offset:
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = store byte replicated into all 4 lanes.
  - SH: wstrb = 4'b0011 << addr[1:0]; wdata = store halfword replicated into both halves.
  - SW: wstrb = 4'b1111.
- Loads: select the byte or half by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Loads: data_size encodes the access width; data_wstrb = 0.
- A data_data_ok seen in REQ, IDLE or DONE is ignored; it does not occur under the bus protocol.
- Reset asserted mid-transaction abandons the transaction. The bus slave shares resetn.

Test Plan:
- ADDU result 0x00000007, dest 3 → out_valid the next cycle; out_result 0x7, out_wen 1, data_req never asserted.
- LB addr 0x80000003; rdata 0x80FF1234 with addr_ok at N+1 and data_ok at N+3 → data_size 0, out_result 0xFFFFFF80, in_ready 0 for cycles N+1..N+3.
- SH addr 0x80000002, store 0x0000BEEF → data_wstrb 4'b1100, data_wdata 0xBEEFBEEF, data_wr 1; out_wen 0 after data_ok.
- LW addr 0x80000006 → no data_req; out_adel 1, out_badvaddr 0x80000006, out_wen 0.
- LHU in DONE with out_ready=0 for 3 cycles → outputs held constant, in_ready 0. out_ready=1 together with a new in_valid → next instruction accepted on the same edge.
- resetn pulled low during WAIT → outputs go to reset values immediately. After release, data_req stays 0 until a new accept.
